acpo_wb_arbiter: RTL and testbench
==================================

# acpo_wb_arbiter

Round-robin write-back arbiter that merges the POOL_NUM pooling-lane result streams of the activation+pooling stage into one SRAM write port. Each lane has a small FIFO because pooling lanes have no back-pressure. The arbiter drains the FIFOs through a single registered valid/ready output. It also tracks per-lane `last` markers to raise a one-cycle layer-done pulse once every lane has finished and all buffered results have been written.

## Interface
- POOL_NUM, 16, number of pooling lanes
- DATA_WIDTH, 8, pooled result width
- ADDRESS_WIDTH, 10, result address width
- FIFO_DEPTH, 4, entries per lane FIFO (power of two, ≥2)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- start_i  input  1  one-cycle pulse, begins a layer
- pool_last_i[POOL_NUM]  input  1  lane's final result of the layer (qualified by valid)
- pool_valid_i[POOL_NUM]  input  1  lane result valid
- pool_result_i[POOL_NUM]  input  DATA_WIDTH  lane result
- pool_result_address_i[POOL_NUM]  input  ADDRESS_WIDTH  lane result address
- wr_valid_o  output  1  write request
- wr_ready_i  input  1  SRAM accepts write
- wr_data_o  output  DATA_WIDTH  write data
- wr_addr_o  output  ADDRESS_WIDTH  write address
- wr_lane_o  output  $clog2(POOL_NUM)  source lane of current write
- wr_last_o  output  1  current write carries lane's last flag
- overflow_o  output  POOL_NUM  sticky per-lane drop flag
- busy_o  output  1  FSM in RUN
- layer_done_o  output  1  one-cycle done pulse

## Operation
- Per-lane FIFO entry = {last, address, data}. Push on pool_valid_i in every FSM state.
- Full lane + valid with no pop that cycle: drop the entry and set overflow_o[lane]. Full + valid + pop in the same cycle: accepted, no drop.
- Output register: loads when empty, or when wr_valid_o && wr_ready_i. Holds data/addr/lane/last stable while wr_valid_o && !wr_ready_i.
- Arbitration: round-robin over non-empty FIFOs. Search begins at rr_ptr, where rr_ptr = last granted lane + 1 mod POOL_NUM. The selected FIFO pops in the same cycle the output register loads.
- Lane completion: lane_done[i] sets when the write from lane i with wr_last_o=1 completes (valid && ready).
- FSM states:
  - IDLE: busy_o=0. start_i → RUN; clears lane_done, overflow_o and rr_ptr.
  - RUN: busy_o=1. When all lane_done are set, all FIFOs are empty and the output register is empty → DONE.
  - DONE: layer_done_o=1 for exactly one cycle → IDLE.
- start_i outside IDLE is ignored.
- FIFOs are never flushed by start_i. Only reset clears them.

## Timing
- Reset values: wr_valid_o=0, wr_data_o=0, wr_addr_o=0, wr_lane_o=0, wr_last_o=0, overflow_o=0, busy_o=0, layer_done_o=0. FSM=IDLE, rr_ptr=0, all FIFOs empty.
- Latency: pool_valid_i at edge N → wr_valid_o high after edge N+1, when uncontended and the output register is free.
- Throughput: one write per cycle while wr_ready_i=1.
- layer_done_o rises the cycle after the final handshake that meets the RUN exit condition.
- Reset asserted mid-operation: all state clears immediately, in-flight entries are lost and no done pulse is issued.
- Lane pointers wrap modulo FIFO_DEPTH. Full/empty uses an extra pointer bit.

## Structure
- Package acpo_pkg holds:
  - default widths;
  - lane index type (logic [$clog2(POOL_NUM)-1:0]);
  - FIFO entry struct {last, addr, data};
  - FSM enum {IDLE, RUN, DONE}.
- Sub-module acpo_lane_fifo: single-clock FIFO with push/pop/full/empty, instantiated POOL_NUM times via generate.
- Round-robin pick and the FSM live in the top module.

## Test plan
- Single lane: lane 3 sends data 0x5A, addr 0x010, last=1, with wr_ready_i=1. Required: wr_valid_o two cycles later, wr_lane_o=3, wr_last_o=1. layer_done_o pulses only if the other 15 lanes also finished, otherwise no pulse.
- Contention: all 16 lanes valid in one cycle with wr_ready_i=1. Required: 16 consecutive writes with lanes in order 0..15; a second burst then starts at lane 0 after rr_ptr wraps.
- Back-pressure: wr_ready_i=0 for 10 cycles while lane 0 streams 6 results into FIFO_DEPTH=4. Required: output holds stable; lane 0 holds 4 entries and 1 sits in the output register; the 6th is dropped and overflow_o[0]=1; after release, 5 writes in order.
- Full + pop: lane FIFO full, wr_ready_i=1, and a new valid in the same cycle. Required: no drop, overflow_o stays 0.
- Full layer: start_i, then every lane sends 4 results with the last on the 4th. Required: 64 writes, busy_o=1 throughout, layer_done_o exactly one cycle after the 64th handshake, then IDLE.
- Reset mid-layer: assert rst while FIFOs hold data. Required: all outputs return to reset values asynchronously, with no wr_valid_o and no layer_done_o after release.

Source files
------------

// File: rtl/acpo_pkg.sv
// Shared definitions for the activation+pooling write-back arbiter:
// default widths, lane index and FIFO entry types, FSM encoding and a
// small modular-wrap helper used by the round-robin search.
package acpo_pkg;

    localparam int POOL_NUM_DEF      = 16;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ADDRESS_WIDTH_DEF = 10;
    localparam int FIFO_DEPTH_DEF    = 4;
    localparam int LANE_W_DEF        = $clog2(POOL_NUM_DEF);

    // Lane index at the default lane count.
    typedef logic [LANE_W_DEF-1:0] lane_idx_t;

    // One buffered pooling result, packed MSB-first as {last, addr, data}.
    typedef struct packed {
        logic                         last;
        logic [ADDRESS_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0]    data;
    } acpo_entry_t;

    // Layer sequencing states.
    typedef enum logic [1:0] {
        ACPO_IDLE = 2'd0,
        ACPO_RUN  = 2'd1,
        ACPO_DONE = 2'd2
    } acpo_state_e;

    // Wraps an index known to be below 2*n back into 0..n-1, without
    // needing a divider for non power-of-two lane counts.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/acpo_lane_fifo.sv
// Single-clock per-lane FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits are equal. A push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module acpo_lane_fifo
    import acpo_pkg::*;
#(
    parameter int WIDTH = 1 + ADDRESS_WIDTH_DEF + DATA_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign wr_ptr_d = push_ok ? (wr_ptr_q + (PTR_W + 1)'(1)) : wr_ptr_q;
    assign rd_ptr_d = pop_ok  ? (rd_ptr_q + (PTR_W + 1)'(1)) : rd_ptr_q;

    assign data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

    // Read/write pointers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/acpo_wb_arbiter.sv
// Round-robin write-back arbiter: buffers each pooling lane in its own
// FIFO, drains them one entry per cycle into a registered valid/ready
// write port, and pulses layer_done_o once every lane has written its
// last result and nothing is left buffered.
module acpo_wb_arbiter
    import acpo_pkg::*;
#(
    parameter int POOL_NUM      = POOL_NUM_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [POOL_NUM-1:0]         pool_last_i,
    input  logic [POOL_NUM-1:0]         pool_valid_i,
    input  logic [DATA_WIDTH-1:0]       pool_result_i [POOL_NUM],
    input  logic [ADDRESS_WIDTH-1:0]    pool_result_address_i [POOL_NUM],
    output logic                        wr_valid_o,
    input  logic                        wr_ready_i,
    output logic [DATA_WIDTH-1:0]       wr_data_o,
    output logic [ADDRESS_WIDTH-1:0]    wr_addr_o,
    output logic [$clog2(POOL_NUM)-1:0] wr_lane_o,
    output logic                        wr_last_o,
    output logic [POOL_NUM-1:0]         overflow_o,
    output logic                        busy_o,
    output logic                        layer_done_o
);

    localparam int LANE_W  = $clog2(POOL_NUM);
    localparam int ENTRY_W = 1 + ADDRESS_WIDTH + DATA_WIDTH;

    // Per-lane FIFO plumbing.
    logic [ENTRY_W-1:0]  fifo_din  [POOL_NUM];
    logic [ENTRY_W-1:0]  fifo_dout [POOL_NUM];
    logic [POOL_NUM-1:0] fifo_full;
    logic [POOL_NUM-1:0] fifo_empty;
    logic [POOL_NUM-1:0] fifo_pop;
    logic [POOL_NUM-1:0] lane_drop;

    // Round-robin selection.
    logic [LANE_W-1:0]   rr_ptr_q;
    logic [LANE_W-1:0]   rr_ptr_d;
    logic [LANE_W-1:0]   cand;
    logic [LANE_W-1:0]   grant_lane;
    logic                grant_valid;
    logic [ENTRY_W-1:0]  grant_entry;

    // Output register.
    logic                wr_valid_q;
    logic                wr_valid_d;
    logic [ENTRY_W-1:0]  wr_entry_q;
    logic [ENTRY_W-1:0]  wr_entry_d;
    logic [LANE_W-1:0]   wr_lane_q;
    logic [LANE_W-1:0]   wr_lane_d;
    logic                load_en;
    logic                handshake;

    // Layer tracking.
    acpo_state_e         state_q;
    acpo_state_e         state_d;
    logic [POOL_NUM-1:0] lane_done_q;
    logic [POOL_NUM-1:0] lane_done_d;
    logic [POOL_NUM-1:0] done_set;
    logic [POOL_NUM-1:0] overflow_q;
    logic [POOL_NUM-1:0] overflow_d;
    logic                start_clear;
    logic                layer_exit;

    // The output register takes a new entry whenever it is empty or its
    // current entry is being accepted this cycle.
    assign load_en   = !wr_valid_q || wr_ready_i;
    assign handshake = wr_valid_q && wr_ready_i;

    genvar g;
    generate
        for (g = 0; g < POOL_NUM; g++) begin : g_lane
            assign fifo_din[g]  = {pool_last_i[g], pool_result_address_i[g], pool_result_i[g]};
            assign fifo_pop[g]  = load_en && grant_valid && (grant_lane == LANE_W'(g));
            assign lane_drop[g] = pool_valid_i[g] && fifo_full[g] && !fifo_pop[g];

            acpo_lane_fifo #(
                .WIDTH (ENTRY_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push_i  (pool_valid_i[g]),
                .pop_i   (fifo_pop[g]),
                .data_i  (fifo_din[g]),
                .data_o  (fifo_dout[g]),
                .full_o  (fifo_full[g]),
                .empty_o (fifo_empty[g])
            );
        end
    endgenerate

    // Pick the first non-empty lane at or after rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = '0;
        cand        = '0;
        for (int k = 0; k < POOL_NUM; k++) begin
            cand = LANE_W'(rr_wrap(int'(rr_ptr_q) + k, POOL_NUM));
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_lane  = cand;
            end
        end
    end

    assign grant_entry = fifo_dout[grant_lane];

    // Output register next state: load the granted entry, or hold while stalled.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_entry_d = wr_entry_q;
        wr_lane_d  = wr_lane_q;
        if (load_en) begin
            wr_valid_d = grant_valid;
            if (grant_valid) begin
                wr_entry_d = grant_entry;
                wr_lane_d  = grant_lane;
            end
        end
    end

    // Lane completion, sticky drop flags and the round-robin pointer.
    // A start in IDLE clears them first; same-cycle events still register.
    always_comb begin
        start_clear = (state_q == ACPO_IDLE) && start_i;

        done_set = '0;
        if (handshake && wr_entry_q[ENTRY_W-1]) begin
            done_set[wr_lane_q] = 1'b1;
        end

        lane_done_d = (start_clear ? '0 : lane_done_q) | done_set;
        overflow_d  = (start_clear ? '0 : overflow_q) | lane_drop;

        rr_ptr_d = rr_ptr_q;
        if (load_en && grant_valid) begin
            rr_ptr_d = LANE_W'(rr_wrap(int'(grant_lane) + 1, POOL_NUM));
        end
        if (start_clear) begin
            rr_ptr_d = '0;
        end
    end

    // The layer is complete once, after this edge, every lane is done and
    // nothing is buffered. An empty output register next cycle already
    // implies every FIFO was empty now, so only new pushes need excluding.
    assign layer_exit = (&lane_done_d) && !wr_valid_d && !(|pool_valid_i);

    // Layer sequencing: IDLE -> RUN on start, RUN -> DONE on completion,
    // DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACPO_IDLE: if (start_i)    state_d = ACPO_RUN;
            ACPO_RUN:  if (layer_exit) state_d = ACPO_DONE;
            ACPO_DONE:                 state_d = ACPO_IDLE;
            default:                   state_d = ACPO_IDLE;
        endcase
    end

    // All arbiter state, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACPO_IDLE;
            rr_ptr_q    <= '0;
            lane_done_q <= '0;
            overflow_q  <= '0;
            wr_valid_q  <= 1'b0;
            wr_entry_q  <= '0;
            wr_lane_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lane_done_q <= lane_done_d;
            overflow_q  <= overflow_d;
            wr_valid_q  <= wr_valid_d;
            wr_entry_q  <= wr_entry_d;
            wr_lane_q   <= wr_lane_d;
        end
    end

    assign wr_valid_o   = wr_valid_q;
    assign wr_last_o    = wr_entry_q[ENTRY_W-1];
    assign wr_addr_o    = wr_entry_q[DATA_WIDTH +: ADDRESS_WIDTH];
    assign wr_data_o    = wr_entry_q[DATA_WIDTH-1:0];
    assign wr_lane_o    = wr_lane_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = (state_q == ACPO_RUN);
    assign layer_done_o = (state_q == ACPO_DONE);

endmodule

// File: tb/tb_acpo_wb_arbiter.sv
// Scoreboard bench for the write-back arbiter. A queue-based reference
// model predicts the write stream and layer status; a negedge monitor
// pops predicted writes at each handshake and compares.
module tb_acpo_wb_arbiter;

    localparam int N     = 16;
    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int LW    = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [N-1:0]   pool_last_i = '0;
    logic [N-1:0]   pool_valid_i = '0;
    logic [DW-1:0]  pool_result_i [N];
    logic [AW-1:0]  pool_result_address_i [N];
    logic           wr_valid_o;
    logic           wr_ready_i = 1'b0;
    logic [DW-1:0]  wr_data_o;
    logic [AW-1:0]  wr_addr_o;
    logic [LW-1:0]  wr_lane_o;
    logic           wr_last_o;
    logic [N-1:0]   overflow_o;
    logic           busy_o;
    logic           layer_done_o;

    acpo_wb_arbiter dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_i               (start_i),
        .pool_last_i           (pool_last_i),
        .pool_valid_i          (pool_valid_i),
        .pool_result_i         (pool_result_i),
        .pool_result_address_i (pool_result_address_i),
        .wr_valid_o            (wr_valid_o),
        .wr_ready_i            (wr_ready_i),
        .wr_data_o             (wr_data_o),
        .wr_addr_o             (wr_addr_o),
        .wr_lane_o             (wr_lane_o),
        .wr_last_o             (wr_last_o),
        .overflow_o            (overflow_o),
        .busy_o                (busy_o),
        .layer_done_o          (layer_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] lane;
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // Reference model state: one queue per lane, one output slot, a
    // round-robin start lane, layer phase 0=idle 1=run 2=done.
    wr_t      laneQ [N][$];
    wr_t      expQ [$];
    wr_t      mOut;
    bit       mOutValid;
    int       mRr;
    bit [N-1:0] mDone;
    bit [N-1:0] mOvf;
    int       mPhase;
    bit       mStarting;
    bit       mAllEmpty;
    int       mLane;

    int compCount = 0;
    int failCount = 0;
    int writesSeen = 0;
    int donePulses = 0;

    wr_t      got;
    logic [N-1:0] vMask;
    logic [N-1:0] lMask;
    int       sent [N];
    int       w0;
    int       p0;
    int       waitCnt;
    int       cyc;
    bit       allSent;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last,
                                 input logic ready, input logic start);
        @(posedge clk);
        #1;
        pool_valid_i = valid;
        pool_last_i  = last & valid;
        wr_ready_i   = ready;
        start_i      = start;
        for (int i = 0; i < N; i++) begin
            pool_result_i[i]         = DW'($urandom);
            pool_result_address_i[i] = AW'($urandom);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_wr_valid", 32'(wr_valid_o), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data_o), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        checkOutput("rst_wr_lane", 32'(wr_lane_o), 32'd0);
        checkOutput("rst_wr_last", 32'(wr_last_o), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_layer_done", 32'(layer_done_o), 32'd0);
    endtask

    // Reference model: advances one edge using the rules of the arbiter
    // expressed with queues and modular arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) laneQ[i].delete();
            expQ.delete();
            mOutValid = 1'b0;
            mOut      = '0;
            mRr       = 0;
            mDone     = '0;
            mOvf      = '0;
            mPhase    = 0;
        end else begin
            mStarting = (mPhase == 0) && start_i;
            if (mStarting) begin
                mDone = '0;
                mOvf  = '0;
            end
            if (mOutValid && wr_ready_i && mOut.last) mDone[mOut.lane] = 1'b1;
            if (!mOutValid || wr_ready_i) begin
                mOutValid = 1'b0;
                for (int k = 0; k < N; k++) begin
                    mLane = (mRr + k) % N;
                    if (!mOutValid && laneQ[mLane].size() > 0) begin
                        mOut      = laneQ[mLane].pop_front();
                        mOutValid = 1'b1;
                        expQ.push_back(mOut);
                        mRr       = (mLane + 1) % N;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (pool_valid_i[i]) begin
                    if (laneQ[i].size() < DEPTH)
                        laneQ[i].push_back({LW'(i), pool_last_i[i], pool_result_address_i[i], pool_result_i[i]});
                    else
                        mOvf[i] = 1'b1;
                end
            end
            if (mStarting) mRr = 0;
            mAllEmpty = !mOutValid;
            for (int i = 0; i < N; i++) if (laneQ[i].size() > 0) mAllEmpty = 1'b0;
            case (mPhase)
                0: if (start_i) mPhase = 1;
                1: if ((&mDone) && mAllEmpty) mPhase = 2;
                default: mPhase = 0;
            endcase
        end
    end

    // Monitor: per-cycle status against the model, and write contents
    // against the scoreboard at every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("wr_valid", 32'(wr_valid_o), 32'(mOutValid));
            checkOutput("busy", 32'(busy_o), 32'(mPhase == 1));
            checkOutput("layer_done", 32'(layer_done_o), 32'(mPhase == 2));
            checkOutput("overflow", 32'(overflow_o), 32'(mOvf));
            if (layer_done_o) donePulses++;
            if (wr_valid_o && wr_ready_i) begin
                writesSeen++;
                if (expQ.size() == 0) begin
                    compCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_write: lane %0d data 0x%0h, required no write", wr_lane_o, wr_data_o);
                end else begin
                    got = expQ.pop_front();
                    checkOutput("wr_lane", 32'(wr_lane_o), 32'(got.lane));
                    checkOutput("wr_data", 32'(wr_data_o), 32'(got.data));
                    checkOutput("wr_addr", 32'(wr_addr_o), 32'(got.addr));
                    checkOutput("wr_last", 32'(wr_last_o), 32'(got.last));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pool_result_i[i]         = '0;
            pool_result_address_i[i] = '0;
        end

        // Reset values
        #1;
        checkResetValues();
        #15;
        rst_n = 1'b1;

        // Single lane: lane 3, data 0x5A, addr 0x010, last
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus(N'(1) << 3, N'(1) << 3, 1'b1, 1'b0);
        pool_result_i[3]         = 8'h5A;
        pool_result_address_i[3] = 10'h010;
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("single_not_yet", 32'(wr_valid_o), 32'd0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("single_valid", 32'(wr_valid_o), 32'd1);
        checkOutput("single_lane", 32'(wr_lane_o), 32'd3);
        checkOutput("single_last", 32'(wr_last_o), 32'd1);
        checkOutput("single_data", 32'(wr_data_o), 32'h5A);
        checkOutput("single_addr", 32'(wr_addr_o), 32'h010);
        repeat (4) applyStimulus('0, '0, 1'b1, 1'b0);

        // Contention: two bursts of all lanes
        repeat (2) begin
            applyStimulus('1, '0, 1'b1, 1'b0);
            repeat (20) applyStimulus('0, '0, 1'b1, 1'b0);
        end

        // Back-pressure: lane 0 streams 6 results into a stalled port
        w0 = writesSeen;
        for (int c = 0; c < 10; c++) applyStimulus((c < 6) ? N'(1) : N'(0), '0, 1'b0, 1'b0);
        checkOutput("bp_overflow0", 32'(overflow_o[0]), 32'd1);
        repeat (15) applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("bp_writes", 32'(writesSeen - w0), 32'd5);

        // Full + pop on lane 5
        for (int c = 0; c < 5; c++) applyStimulus(N'(1) << 5, '0, 1'b0, 1'b0);
        applyStimulus(N'(1) << 5, '0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("fullpop_overflow5", 32'(overflow_o[5]), 32'd0);
        repeat (10) applyStimulus('0, '0, 1'b1, 1'b0);

        // Reset mid-layer with data buffered (start here is outside IDLE)
        applyStimulus(16'h00FF, '0, 1'b0, 1'b1);
        applyStimulus(16'hFF00, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("post_rst_valid", 32'(wr_valid_o), 32'd0);
        checkOutput("post_rst_done_pulses", 32'(donePulses), 32'd0);

        // Full layer: every lane sends 4 results, last on the 4th
        for (int i = 0; i < N; i++) sent[i] = 0;
        applyStimulus('0, '0, 1'b1, 1'b1);
        w0 = writesSeen;
        p0 = donePulses;
        cyc = 0;
        allSent = 1'b0;
        while (!allSent && cyc < 200) begin
            vMask = '0;
            lMask = '0;
            for (int i = 0; i < N; i++) begin
                if (sent[i] < 4 && $urandom_range(0, 1) == 1) begin
                    vMask[i] = 1'b1;
                    sent[i]++;
                    if (sent[i] == 4) lMask[i] = 1'b1;
                end
            end
            applyStimulus(vMask, lMask, $urandom_range(0, 3) != 0, 1'b0);
            allSent = 1'b1;
            for (int i = 0; i < N; i++) if (sent[i] < 4) allSent = 1'b0;
            cyc++;
        end
        waitCnt = 0;
        while (donePulses == p0 && waitCnt < 300) begin
            applyStimulus('0, '0, 1'b1, 1'b0);
            waitCnt++;
        end
        if (donePulses == p0) begin
            compCount++;
            failCount++;
            $display("[TB] FAIL layer_done_timeout: no pulse in 300 cycles, required 1");
        end
        repeat (3) applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("layer_writes", 32'(writesSeen - w0), 32'd64);
        checkOutput("layer_pulses", 32'(donePulses - p0), 32'd1);
        checkOutput("layer_idle_busy", 32'(busy_o), 32'd0);

        // Randomized traffic with occasional starts and lasts
        for (int c = 0; c < 300; c++) begin
            vMask = '0;
            lMask = '0;
            for (int i = 0; i < N; i++) begin
                vMask[i] = ($urandom_range(0, 15) == 0);
                lMask[i] = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(vMask, lMask, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        repeat (80) applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
